// File: rtl/alu_pkg.sv
// Shared definitions for the execute/writeback stage: opcodes, FSM states,
// flag bit positions and small opcode-classification helpers.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_PASS = 4'd6,
        OP_SHL  = 4'd7,
        OP_SHR  = 4'd8,
        OP_MUL  = 4'd9,
        OP_CMP  = 4'd10
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    localparam int FLAG_Z  = 3;
    localparam int FLAG_N  = 2;
    localparam int FLAG_CY = 1;
    localparam int FLAG_V  = 0;

    // Opcodes 11..15 are NOPs; only 0..9 produce a register-file write.
    function automatic logic opWrites(input logic [3:0] op);
        return op <= 4'd9;
    endfunction

    function automatic logic opIsNop(input logic [3:0] op);
        return op >= 4'd11;
    endfunction

    function automatic logic [3:0] packFlags(input logic z, input logic n,
                                             input logic cy, input logic v);
        logic [3:0] f;
        f          = '0;
        f[FLAG_Z]  = z;
        f[FLAG_N]  = n;
        f[FLAG_CY] = cy;
        f[FLAG_V]  = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational single-cycle ALU operations and their status flags.
// Shift opcodes reaching this block always have a zero count, so they pass A.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       flags_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             cy;
    logic             v;

    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        res = '0;
        cy  = 1'b0;
        v   = 1'b0;
        case (op_i)
            OP_ADD: begin
                res = sum[WIDTH-1:0];
                cy  = sum[WIDTH];
                v   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
            end
            // The extra top bit of the zero-extended difference is the borrow.
            OP_SUB, OP_CMP: begin
                res = diff[WIDTH-1:0];
                cy  = diff[WIDTH];
                v   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND:         res = a_i & b_i;
            OP_OR:          res = a_i | b_i;
            OP_XOR:         res = a_i ^ b_i;
            OP_NOT:         res = ~a_i;
            OP_PASS:        res = b_i;
            OP_SHL, OP_SHR: res = a_i;
            default:        res = '0;
        endcase
    end

    assign result_o = res;
    assign flags_o  = packFlags(res == '0, res[WIDTH-1], cy, v);

endmodule

// File: rtl/alu_wb_stage.sv
// Execute/writeback stage: single-cycle ALU ops, bit-serial shifts and a
// shift-add multiplier, driving the register-file write port for one cycle.
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AW    = 4
) (
    input  logic             Clk,
    input  logic             Clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       Opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [AW-1:0]    Daddr,
    output logic [WIDTH-1:0] C,
    output logic [AW-1:0]    Caddr,
    output logic             Load,
    output logic [3:0]       Flags,
    output logic             Busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [3:0]         op_q;
    logic [AW-1:0]      dst_q;
    logic [2*WIDTH-1:0] work_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   c_q;
    logic [AW-1:0]      caddr_q;
    logic [3:0]         flags_q;
    logic               load_q;

    logic               accept;
    logic               startIter;
    logic               iterDone;
    logic [WIDTH-1:0]   aluRes;
    logic [3:0]         aluFlags;
    logic [2*WIDTH-1:0] stepWork;
    logic               stepCy;
    logic [WIDTH-1:0]   iterRes;
    logic               iterCy;

    alu_comb #(.WIDTH(WIDTH)) u_alu (
        .op_i     (Opcode),
        .a_i      (A),
        .b_i      (B),
        .result_o (aluRes),
        .flags_o  (aluFlags)
    );

    assign accept    = in_valid & in_ready;
    assign startIter = (Opcode == OP_MUL) ||
                       (((Opcode == OP_SHL) || (Opcode == OP_SHR)) && (B[3:0] != 4'd0));
    assign iterDone  = (state_q == ST_ITER) && (cnt_q == CW'(1));

    always_ff @(posedge Clk) begin
        if (Clear) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_ITER: state_d = iterDone ? ST_WB : ST_ITER;
            default: begin
                if (accept) state_d = startIter ? ST_ITER : ST_WB;
                else        state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_IDLE) || (state_q == ST_WB);
        Busy     = (state_q == ST_ITER);
        Load     = load_q;
    end

    // One iteration step: a single-bit shift, or one shift-add multiply step.
    always_comb begin
        stepWork = work_q;
        stepCy   = 1'b0;
        case (op_q)
            OP_SHL: begin
                stepWork = {{WIDTH{1'b0}}, work_q[WIDTH-2:0], 1'b0};
                stepCy   = work_q[WIDTH-1];
            end
            OP_SHR: begin
                stepWork = {{(WIDTH+1){1'b0}}, work_q[WIDTH-1:1]};
                stepCy   = work_q[0];
            end
            default: stepWork = mplier_q[0] ? (work_q + mcand_q) : work_q;
        endcase
        iterRes = stepWork[WIDTH-1:0];
        iterCy  = (op_q == OP_MUL) ? (stepWork[2*WIDTH-1:WIDTH] != '0) : stepCy;
    end

    always_ff @(posedge Clk) begin
        if (Clear) begin
            cnt_q    <= '0;
            op_q     <= '0;
            dst_q    <= '0;
            work_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            c_q      <= '0;
            caddr_q  <= '0;
            flags_q  <= '0;
            load_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= Opcode;
                dst_q    <= Daddr;
                cnt_q    <= (Opcode == OP_MUL) ? CW'(WIDTH) : CW'(B[3:0]);
                work_q   <= (Opcode == OP_MUL) ? '0 : {{WIDTH{1'b0}}, A};
                mcand_q  <= {{WIDTH{1'b0}}, A};
                mplier_q <= B;
            end else if (state_q == ST_ITER) begin
                cnt_q    <= cnt_q - CW'(1);
                work_q   <= stepWork;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end

            // Writeback registers change only on the edge that enters WB.
            if (accept && !startIter) begin
                if (opWrites(Opcode)) begin
                    c_q     <= aluRes;
                    caddr_q <= Daddr;
                end
                if (!opIsNop(Opcode)) flags_q <= aluFlags;
                load_q <= opWrites(Opcode);
            end else if (iterDone) begin
                c_q     <= iterRes;
                caddr_q <= dst_q;
                flags_q <= packFlags(iterRes == '0, iterRes[WIDTH-1], iterCy, 1'b0);
                load_q  <= 1'b1;
            end else begin
                load_q  <= 1'b0;
            end
        end
    end

    assign C     = c_q;
    assign Caddr = caddr_q;
    assign Flags = flags_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage with hand-computed expected values.
module tb_alu_wb_stage;

    logic        Clk;
    logic        Clear;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Opcode;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  Daddr;
    logic [15:0] C;
    logic [3:0]  Caddr;
    logic        Load;
    logic [3:0]  Flags;
    logic        Busy;

    int passCount = 0;
    int checkCount = 0;

    alu_wb_stage #(.WIDTH(16), .AW(4)) dut (
        .Clk      (Clk),
        .Clear    (Clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Opcode   (Opcode),
        .A        (A),
        .B        (B),
        .Daddr    (Daddr),
        .C        (C),
        .Caddr    (Caddr),
        .Load     (Load),
        .Flags    (Flags),
        .Busy     (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one clock and sample shortly after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [3:0] d);
        in_valid = 1'b1;
        Opcode   = op;
        A        = a;
        B        = b;
        Daddr    = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    initial begin
        int n;
        int loads;

        in_valid = 1'b0;
        Opcode   = 4'd0;
        A        = '0;
        B        = '0;
        Daddr    = '0;
        Clear    = 1'b1;
        tick();
        tick();
        checkOutput("reset_C", 32'(C), 32'h0);
        checkOutput("reset_Caddr", 32'(Caddr), 32'h0);
        checkOutput("reset_Load", 32'(Load), 32'h0);
        checkOutput("reset_Flags", 32'(Flags), 32'h0);
        checkOutput("reset_Busy", 32'(Busy), 32'h0);
        checkOutput("reset_ready", 32'(in_ready), 32'h1);
        Clear = 1'b0;
        tick();

        // ADD with carry out to zero
        applyStimulus(4'd0, 16'hFFFF, 16'h0001, 4'd3);
        tick();
        in_valid = 1'b0;
        checkOutput("add_Load", 32'(Load), 32'h1);
        checkOutput("add_C", 32'(C), 32'h0);
        checkOutput("add_Caddr", 32'(Caddr), 32'h3);
        checkOutput("add_Flags", 32'(Flags), 32'b1010);

        // SUB then back-to-back CMP
        applyStimulus(4'd1, 16'd5, 16'd7, 4'd1);
        tick();
        checkOutput("sub_Load", 32'(Load), 32'h1);
        checkOutput("sub_C", 32'(C), 32'hFFFE);
        checkOutput("sub_Caddr", 32'(Caddr), 32'h1);
        checkOutput("sub_Flags", 32'(Flags), 32'b0110);
        applyStimulus(4'd10, 16'd7, 16'd7, 4'd9);
        tick();
        in_valid = 1'b0;
        checkOutput("cmp_Load", 32'(Load), 32'h0);
        checkOutput("cmp_Flags", 32'(Flags), 32'b1000);
        checkOutput("cmp_C_hold", 32'(C), 32'hFFFE);
        tick();
        checkOutput("idle_Load", 32'(Load), 32'h0);

        // SHL by 4: four busy cycles, then write
        applyStimulus(4'd7, 16'h8001, 16'd4, 4'd2);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("shl_busy%0d", i), 32'(Busy), 32'h1);
            checkOutput($sformatf("shl_ready%0d", i), 32'(in_ready), 32'h0);
            checkOutput($sformatf("shl_noload%0d", i), 32'(Load), 32'h0);
            tick();
        end
        checkOutput("shl_Busy_done", 32'(Busy), 32'h0);
        checkOutput("shl_Load", 32'(Load), 32'h1);
        checkOutput("shl_C", 32'(C), 32'h0010);
        checkOutput("shl_Caddr", 32'(Caddr), 32'h2);
        checkOutput("shl_Flags", 32'(Flags), 32'b0000);

        // SHR by 1 shifts out a one
        applyStimulus(4'd8, 16'h0003, 16'd1, 4'd4);
        tick();
        in_valid = 1'b0;
        checkOutput("shr_Busy", 32'(Busy), 32'h1);
        tick();
        checkOutput("shr_Load", 32'(Load), 32'h1);
        checkOutput("shr_C", 32'(C), 32'h0001);
        checkOutput("shr_Flags", 32'(Flags), 32'b0010);

        // MUL 300*300 with upstream holding a different op during ITER
        applyStimulus(4'd9, 16'd300, 16'd300, 4'd15);
        tick();
        applyStimulus(4'd0, 16'hFFFF, 16'h1234, 4'd7);
        checkOutput("mul_ready", 32'(in_ready), 32'h0);
        checkOutput("mul_Busy", 32'(Busy), 32'h1);
        n = 0;
        while (Load !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checkOutput("mul_latency", 32'(n + 1), 32'd17);
        checkOutput("mul_C", 32'(C), 32'h5F90);
        checkOutput("mul_Caddr", 32'(Caddr), 32'hF);
        checkOutput("mul_Flags", 32'(Flags), 32'b0010);
        tick();
        in_valid = 1'b0;
        checkOutput("held_add_C", 32'(C), 32'h1233);
        checkOutput("held_add_Caddr", 32'(Caddr), 32'h7);
        checkOutput("held_add_Flags", 32'(Flags), 32'b0010);
        tick();

        // Clear in the middle of a multiply
        applyStimulus(4'd9, 16'd300, 16'd300, 4'd5);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        checkOutput("clr_Busy", 32'(Busy), 32'h0);
        checkOutput("clr_Load", 32'(Load), 32'h0);
        checkOutput("clr_C", 32'(C), 32'h0);
        checkOutput("clr_Caddr", 32'(Caddr), 32'h0);
        checkOutput("clr_Flags", 32'(Flags), 32'h0);
        checkOutput("clr_ready", 32'(in_ready), 32'h1);
        loads = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (Load === 1'b1) loads++;
        end
        checkOutput("clr_no_load", 32'(loads), 32'd0);
        applyStimulus(4'd0, 16'd2, 16'd3, 4'd6);
        tick();
        in_valid = 1'b0;
        checkOutput("post_clr_Load", 32'(Load), 32'h1);
        checkOutput("post_clr_C", 32'(C), 32'h5);
        checkOutput("post_clr_Caddr", 32'(Caddr), 32'h6);

        // NOP after an overflowing ADD leaves flags alone
        applyStimulus(4'd0, 16'h7FFF, 16'h0001, 4'd8);
        tick();
        checkOutput("ovf_Flags", 32'(Flags), 32'b0101);
        applyStimulus(4'd13, 16'h0000, 16'h0000, 4'd0);
        tick();
        in_valid = 1'b0;
        checkOutput("nop_Load", 32'(Load), 32'h0);
        checkOutput("nop_Flags", 32'(Flags), 32'b0101);
        checkOutput("nop_C", 32'(C), 32'h8000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/alu_wb_stage.md
# alu_wb_stage

Execute/writeback stage sitting directly downstream of the 16×16 register file. It accepts the two read operands, an opcode and a destination address. It computes a 16-bit result, single-cycle or iterative, and drives the register file's write port (`C`, `Caddr`, `Load`) for exactly one cycle per writing operation. It also maintains a registered status-flag word.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width (only 16 is verified)
- `AW`, 4, register address width

Ports:
- `Clk` in 1: rising-edge clock
- `Clear` in 1: synchronous, active-high reset
- `in_valid` in 1: operation presented on `Opcode`/`A`/`B`/`Daddr`
- `in_ready` out 1: stage can accept; transfer when `in_valid & in_ready` at a rising edge
- `Opcode` in 4: operation select
- `A`, `B` in 16: operands from register file
- `Daddr` in 4: destination register
- `C` out 16: writeback data
- `Caddr` out 4: writeback address
- `Load` out 1: write strobe to register file, 1-cycle pulse
- `Flags` out 4: {Z, N, Cy, V}
- `Busy` out 1: high in ITER state

## Operation
- Opcodes:
  - 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 PASS B
  - 7 SHL A by B[3:0], 8 SHR (logical) A by B[3:0]
  - 9 MUL (low 16 bits of A×B, unsigned)
  - 10 CMP (A−B, flags only)
  - 11–15 NOP
- FSM states: IDLE, ITER, WB.
  - IDLE/WB with accept:
    - ops 0–6, 10–15 → WB
    - SHL/SHR with B[3:0]=0 → WB, result = A
    - SHL/SHR with count≥1 → ITER
    - MUL → ITER
  - IDLE or WB without accept → IDLE.
  - ITER: down-counter decrements each cycle; → WB when the counter reaches 0 on that edge.
- Iterative datapath:
  - Shifts move one bit per ITER cycle.
  - MUL is shift-add, one multiplier bit per cycle, 16 cycles, with a 32-bit accumulator.
  - Operands are captured at accept; input changes during ITER are ignored.
- `in_ready` = (state==IDLE) | (state==WB), giving back-to-back single-cycle ops.
- `Load`=1 only in WB and only for ops 0–9. CMP and NOP give `Load`=0 in their WB cycle.
- `C`/`Caddr` are registered and change only on entry to WB. They hold their values otherwise.
- Flags update on entry to WB, except NOP, which leaves them unchanged.
  - Z = result==0; N = result[15]
  - ADD: Cy = carry out; V = signed overflow
  - SUB/CMP: Cy = borrow (A<B unsigned); V = signed overflow
  - Logic ops and PASS B: Cy=0, V=0
  - Shifts: Cy = last bit shifted out (0 when count is 0); V=0
  - MUL: Cy = (product[31:16]≠0); V=0
- All arithmetic is modulo 2^16.

## Timing
- Reset (`Clear`=1 at an edge): state IDLE, `C`=0, `Caddr`=0, `Load`=0, `Flags`=0, `Busy`=0, counter 0. `in_ready`=1 the next cycle.
- Reset has priority over everything. `Clear` during ITER or WB aborts the operation, and no `Load` pulse is issued.
- Latency from accept edge to the edge at which the register file samples `Load`=1:
  - single-cycle ops: 1 cycle
  - shifts: count+1 cycles
  - MUL: 17 cycles
- Throughput: one single-cycle op per clock while `in_valid` stays high.
- `in_valid` during ITER is not accepted (`in_ready`=0); the upstream stage holds it.
- An accept in WB starts the next op on the same edge as the current write completes; the WB outputs of the current op are unaffected.

## Structure
- Shared package `alu_pkg`:
  - opcode constants
  - state encoding
  - flag bit indices (Z=3, N=2, Cy=1, V=0)
- One sub-module, `alu_comb`: purely combinational single-cycle ops plus flag generation. Iterative shift/MUL control and the FSM stay in the top level.

## Test plan
- Reset, then ADD A=16'hFFFF B=16'h0001 Daddr=3 → next cycle `Load`=1, `C`=0, `Caddr`=3, `Flags`=4'b1010.
- SUB A=5 B=7 Daddr=1, then back-to-back CMP A=7 B=7 → first WB: `C`=16'hFFFE, `Flags`=4'b0110. Second WB: `Load`=0, `Flags`=4'b1000, `C` holds 16'hFFFE.
- SHL A=16'h8001 B=4 Daddr=2 → `Busy` for 4 cycles, `in_ready`=0, `Load` at accept+5, `C`=16'h0010, Cy=0. Then SHR A=16'h0003 B=1 → `C`=1, Cy=1.
- MUL A=300 B=300 Daddr=15 → `Load` exactly 17 cycles after accept, `C`=16'h5F90, Cy=1. Operand changes during ITER have no effect.
- `Clear` asserted mid-MUL (cycle 8) → no `Load` pulse, all outputs return to reset values, and a following ADD 2+3 writes 5 with latency 1.
- NOP opcode 13 after ADD → WB with `Load`=0 and `Flags` unchanged from the ADD.
